// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int BCD_W  = DIGITS * 4;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int ITER   = 14;
    localparam int CNT_W  = 4;

    localparam logic [BIN_W-1:0] MAX_DEC   = 14'd9999;
    localparam logic [3:0]       OVF_CODE  = 4'hA;
    localparam logic [CNT_W-1:0] LAST_ITER = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVF   = 2'd2
    } state_t;

    // Display word shown for out-of-range inputs: a dash in every digit.
    function automatic logic [BCD_W-1:0] ovf_word();
        return {DIGITS{OVF_CODE}};
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_adj_digit.sv
// One double-dabble correction step for a single BCD digit.
module bcd_adj_digit (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Add 3 to digits of 5 or more so the following shift carries correctly.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3),
// one bit per cycle, with a single-cycle path for values above 9999.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] in_bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BCD_W-1:0] bcd_out,
    output logic             out_valid,
    output logic             overflow
);

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                vld_q, vld_d;
    logic [BCD_W-1:0]    adj_s;
    logic [WORK_W-1:0]   shift_s;
    logic                accept_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj_digit u_adj (
            .digit_i (work_q[BIN_W + 4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
        );
    end

    // Adjusted digits above the untouched binary part, shifted as one word.
    always_comb begin
        shift_s  = {adj_s, work_q[BIN_W-1:0]} << 1;
        accept_s = in_valid && (state_q == IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = (in_bin > MAX_DEC) ? OVF : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            OVF:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath next values; results only change when a conversion finishes.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        vld_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    work_d = {{BCD_W{1'b0}}, in_bin};
                    cnt_d  = {CNT_W{1'b0}};
                end else begin
                    work_d = work_q;
                end
            end
            SHIFT: begin
                work_d = shift_s;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    bcd_d = shift_s[WORK_W-1:BIN_W];
                    ovf_d = 1'b0;
                    vld_d = 1'b1;
                end else begin
                    vld_d = 1'b0;
                end
            end
            OVF: begin
                bcd_d = ovf_word();
                ovf_d = 1'b1;
                vld_d = 1'b1;
            end
            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= {WORK_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            bcd_q  <= {BCD_W{1'b0}};
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign overflow  = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have the following ports, clock and reset first, one per line as name, direction, width, meaning:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_bin  input  14  unsigned binary value to convert.
- in_valid  input  1  request: in_bin is valid this cycle.
- in_ready  output  1  high when the block can accept a request.
- bcd_out  output  16  four packed BCD digits; [3:0] is ones, [15:12] is thousands.
- out_valid  output  1  one-cycle pulse marking a new bcd_out.
- overflow  output  1  high when the last accepted in_bin exceeded 9999.
REQ-002 SHALL use one clock, clk; reset SHALL be synchronous and active-high.
REQ-003 SHALL have no parameters; widths are fixed by package constants.

Function
REQ-004 SHALL implement a three-state FSM: IDLE, SHIFT, and OVF.
REQ-005 SHALL drive in_ready high only in IDLE.
REQ-006 SHALL accept a request on a rising edge where in_valid and in_ready are both high, and SHALL capture in_bin on that edge (E0).
REQ-007 SHALL ignore in_valid while not in IDLE, without queuing or error.
REQ-008 On acceptance with in_bin at most 9999, SHALL enter SHIFT, load a 30-bit working register with 16'h0000 concatenated with in_bin, and clear a 4-bit iteration counter.
REQ-009 Each SHIFT cycle SHALL add 3 to every BCD nibble of the working register that is 5 or greater, then shift the whole register left by 1.
REQ-010 SHALL perform exactly 14 iterations, on edges E1 through E14.
REQ-011 On E14, SHALL load bcd_out with the upper 16 bits of the final adjusted-and-shifted value, clear overflow, set out_valid, and return to IDLE.
REQ-012 On acceptance with in_bin of 10000 or more, SHALL enter OVF; on E1 it SHALL load bcd_out with 16'hAAAA (digit code 10 in every position, shown as a dash by the display), set overflow, set out_valid, and return to IDLE.
REQ-013 SHALL keep out_valid high for exactly one cycle per accepted request.
REQ-014 SHALL hold bcd_out and overflow stable between conversions, so the display never shows intermediate values.
REQ-015 Back-to-back operation: in_ready rises in the same cycle out_valid is high, so a new request SHALL be acceptable on the edge that ends the out_valid pulse.
REQ-016 Latency: 14 cycles from acceptance to out_valid for normal values; 1 cycle for overflow values.
REQ-017 in_bin = 0 SHALL yield bcd_out = 16'h0000; in_bin = 9999 SHALL yield 16'h9999 with overflow low.

Reset
REQ-018 While reset is high, SHALL force state to IDLE, bcd_out to 16'h0000, out_valid to 0, overflow to 0, the working register to 0, and the counter to 0; in_ready therefore reads 1.
REQ-019 A reset asserted during SHIFT or OVF SHALL abort the conversion, with no out_valid pulse and bcd_out equal to 0 on the following cycle.
REQ-020 A request presented on the reset cycle SHALL NOT be accepted.

Structure
REQ-021 A shared package SHALL hold:
- BIN_W = 14 and DIGITS = 4.
- MAX_DEC = 9999.
- OVF_CODE = 4'hA.
- ITER = 14.
- The state enum (IDLE, SHIFT, OVF).
REQ-022 SHALL instantiate one combinational sub-module, bcd_adj_digit (4-bit in, 4-bit out, adds 3 when the input is 5 or greater), replicated DIGITS times.
REQ-023 bcd_out SHALL connect directly to the 16-bit bcd input of the existing four-digit display driver, with no glue logic.

Verification
REQ-024 After reset, in_bin = 1234 with in_valid pulsed for one cycle -> out_valid exactly 14 cycles later, bcd_out = 16'h1234, overflow = 0.
REQ-025 Boundary values 0, 9, 10, 999, 1000, and 9999 -> bcd_out of 0000, 0009, 0010, 0999, 1000, and 9999 respectively; also sweep all values 0 to 9999 against a reference model.
REQ-026 in_bin = 10000, then in_bin = 16383 -> out_valid after 1 cycle, bcd_out = 16'hAAAA, overflow = 1; a following in_bin = 42 -> 16'h0042 with overflow = 0.
REQ-027 in_valid held high continuously with changing in_bin -> only values present on in_ready-high edges are converted, one out_valid per conversion, and values presented while busy are dropped.
REQ-028 Reset asserted 5 cycles into converting 4321 -> no out_valid, bcd_out = 0, in_ready = 1 on the next cycle; a subsequent conversion of 4321 succeeds.
